// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the traffic light controller.
//   - lamp codes (2-bit per way): off, red, yellow, green
//   - controller state enum
//   - counter width helper and lamp-to-VGA colour mapping
package traffic_pkg;

    localparam logic [1:0] LAMP_OFF    = 2'b00;
    localparam logic [1:0] LAMP_RED    = 2'b01;
    localparam logic [1:0] LAMP_YELLOW = 2'b10;
    localparam logic [1:0] LAMP_GREEN  = 2'b11;

    typedef enum logic [2:0] {
        ALL_RED,
        GREEN,
        YELLOW,
        WALK,
        FLASH
    } state_t;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val < 1)
            return 1;
        return $clog2(max_val + 1);
    endfunction

    // Lamp code to {red,yellow,green} for the VGA path.
    function automatic logic [2:0] lamp_to_rgb(input logic [1:0] lamp);
        case (lamp)
            LAMP_RED:    return 3'b100;
            LAMP_YELLOW: return 3'b010;
            LAMP_GREEN:  return 3'b001;
            default:     return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/traffic_tick_gen.sv
// traffic_tick_gen: timing-tick prescaler.
//   Produces a registered one-cycle pulse every TICK_DIV cycles; the first
//   pulse arrives TICK_DIV cycles after RST (or clr) is released.
// Ports:
//   CLK_50MHz  in   sole clock, rising edge
//   RST        in   synchronous active-high reset
//   clr        in   synchronous restart of the prescaler
//   tick       out  one-cycle tick pulse
module traffic_tick_gen
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic CLK_50MHz,
    input  logic RST,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = cnt_width(TICK_DIV - 1);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK_50MHz) begin
        if (RST || clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/traffic_light_ctrl_param.sv
// traffic_light_ctrl_param: parameterised multi-way traffic light controller.
//   Cycles ALL_RED -> GREEN -> YELLOW -> ALL_RED serving one way at a time,
//   with an optional pedestrian WALK phase and a flashing override.
//   Optional feature macro: TRAFFIC_PED_WALK_EN (ped_req latch, WALK state,
//   walk_out). Without it ped_req is ignored and walk_out is 0.
// Ports:
//   CLK_50MHz  in   sole clock, rising edge
//   RST        in   synchronous active-high reset
//   flash_en   in   level, night/fault flashing override
//   ped_req    in   pedestrian request, sampled every cycle
//   light_out  out  per-way lamp code, way k at [2k+1:2k]
//   cur_way    out  index of the way currently served
//   color_out  out  {red,yellow,green} of cur_way
//   walk_out   out  high only in WALK
//   tick_out   out  one-cycle timing tick pulse
module traffic_light_ctrl_param
    import traffic_pkg::*;
#(
    parameter int unsigned NUM_WAYS     = 2,
    parameter int unsigned TICK_DIV     = 50000000,
    parameter int unsigned GREEN_TICKS  = 5,
    parameter int unsigned YELLOW_TICKS = 2,
    parameter int unsigned ALLRED_TICKS = 1,
    parameter int unsigned WALK_TICKS   = 4
) (
    input  logic                  CLK_50MHz,
    input  logic                  RST,
    input  logic                  flash_en,
    input  logic                  ped_req,
    output logic [2*NUM_WAYS-1:0] light_out,
    output logic [1:0]            cur_way,
    output logic [2:0]            color_out,
    output logic                  walk_out,
    output logic                  tick_out
);

    localparam int unsigned MAX_A   = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
    localparam int unsigned MAX_B   = (ALLRED_TICKS > WALK_TICKS) ? ALLRED_TICKS : WALK_TICKS;
    localparam int unsigned MAX_DUR = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned PW      = cnt_width(MAX_DUR - 1);
    localparam logic [1:0]  LAST_WAY = 2'(NUM_WAYS - 1);

    state_t                state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [1:0]            way_d;
    logic                  lit_q, lit_d;
    logic                  tick;
    logic                  clr;
    logic [2*NUM_WAYS-1:0] light_d;
    logic [2:0]            color_d;

    traffic_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .CLK_50MHz (CLK_50MHz),
        .RST       (RST),
        .clr       (clr),
        .tick      (tick)
    );

    assign tick_out = tick;

`ifdef TRAFFIC_PED_WALK_EN
    logic pending_q, pending_d;
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
`endif

    // Next-state logic; phase_q counts completed ticks within the phase.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        way_d   = cur_way;
        lit_d   = lit_q;
        clr     = 1'b0;
        if (flash_en && state_q != FLASH) begin
            state_d = FLASH;
            phase_d = '0;
            lit_d   = 1'b1;
            clr     = 1'b1;
        end else begin
            case (state_q)
                ALL_RED: if (tick) begin
                    if (phase_q == PW'(ALLRED_TICKS - 1)) begin
                        phase_d = '0;
                        state_d = GREEN;
`ifdef TRAFFIC_PED_WALK_EN
                        if (pending_q)
                            state_d = WALK;
`endif
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                GREEN: if (tick) begin
                    if (phase_q == PW'(GREEN_TICKS - 1)) begin
                        phase_d = '0;
                        state_d = YELLOW;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                YELLOW: if (tick) begin
                    if (phase_q == PW'(YELLOW_TICKS - 1)) begin
                        phase_d = '0;
                        state_d = ALL_RED;
                        way_d   = (cur_way == LAST_WAY) ? 2'd0 : cur_way + 2'd1;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
`ifdef TRAFFIC_PED_WALK_EN
                WALK: if (tick) begin
                    if (phase_q == PW'(WALK_TICKS - 1)) begin
                        phase_d = '0;
                        state_d = ALL_RED;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
`endif
                FLASH: begin
                    if (!flash_en) begin
                        state_d = ALL_RED;
                        phase_d = '0;
                        way_d   = 2'd0;
                    end else if (tick) begin
                        lit_d = ~lit_q;
                    end
                end
                default: begin
                    state_d = ALL_RED;
                    phase_d = '0;
                end
            endcase
        end
    end

`ifdef TRAFFIC_PED_WALK_EN
    // Requests are dropped while in WALK and on the WALK entry edge itself.
    always_comb begin
        pending_d = pending_q;
        if (state_d == WALK && state_q != WALK)
            pending_d = 1'b0;
        else if (state_q != WALK && ped_req)
            pending_d = 1'b1;
    end
`endif

    // Output decode from next-state values so registered outputs line up
    // with the state register.
    always_comb begin
        light_d = '0;
        color_d = 3'b000;
        for (int unsigned k = 0; k < NUM_WAYS; k++) begin : g_lamp
            logic [1:0] lamp;
            lamp = LAMP_RED;
            case (state_d)
                GREEN:   lamp = (2'(k) == way_d) ? LAMP_GREEN : LAMP_RED;
                YELLOW:  lamp = (2'(k) == way_d) ? LAMP_YELLOW : LAMP_RED;
                FLASH:   lamp = !lit_d ? LAMP_OFF : ((k == 0) ? LAMP_YELLOW : LAMP_RED);
                default: lamp = LAMP_RED;
            endcase
            light_d[2*k +: 2] = lamp;
            if (2'(k) == way_d)
                color_d = lamp_to_rgb(lamp);
        end
    end

    always_ff @(posedge CLK_50MHz) begin
        if (RST) begin
            state_q   <= ALL_RED;
            phase_q   <= '0;
            cur_way   <= 2'd0;
            lit_q     <= 1'b0;
            light_out <= {NUM_WAYS{LAMP_RED}};
            color_out <= 3'b100;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cur_way   <= way_d;
            lit_q     <= lit_d;
            light_out <= light_d;
            color_out <= color_d;
        end
    end

`ifdef TRAFFIC_PED_WALK_EN
    always_ff @(posedge CLK_50MHz) begin
        if (RST) begin
            pending_q <= 1'b0;
            walk_out  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            walk_out  <= (state_d == WALK);
        end
    end
`else
    assign walk_out = 1'b0;
`endif

endmodule

// File: doc/traffic_light_ctrl_param.md
TRAFFIC_LIGHT_CTRL_PARAM -- requirements
Module: traffic_light_ctrl_param

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 2, number of approach directions (2..4).
REQ-002 SHALL have parameter TICK_DIV, default 50000000, CLK_50MHz cycles per timing tick (>=1).
REQ-003 SHALL have parameters GREEN_TICKS 5, YELLOW_TICKS 2, ALLRED_TICKS 1, WALK_TICKS 4, phase durations in ticks (each >=1).
REQ-004 SHALL have CLK_50MHz  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have flash_en  input  1  level; night/fault flashing override.
REQ-007 SHALL have ped_req  input  1  pedestrian request, sampled every cycle.
REQ-008 SHALL have light_out  output  2*NUM_WAYS  per-way lamp code, way k at bits [2k+1:2k].
REQ-009 SHALL have cur_way  output  2  index of way currently served.
REQ-010 SHALL have color_out  output  3  {red,yellow,green} of cur_way for the VGA path.
REQ-011 SHALL have walk_out  output  1  high only in WALK.
REQ-012 SHALL have tick_out  output  1  one-cycle timing-tick pulse.

Function
REQ-013 Lamp codes SHALL be 00 off, 01 red, 10 yellow, 11 green.
REQ-014 Tick SHALL pulse one cycle every TICK_DIV cycles; first pulse TICK_DIV cycles after RST deasserts; TICK_DIV=1 pulses every cycle.
REQ-015 States SHALL be ALL_RED, GREEN, YELLOW, WALK, FLASH; phase counter counts ticks and clears on every state change.
REQ-016 ALL_RED SHALL last ALLRED_TICKS ticks, all ways red; exit to WALK if ped pending, else GREEN.
REQ-017 GREEN SHALL light cur_way green, others red, for GREEN_TICKS ticks, then YELLOW.
REQ-018 YELLOW SHALL light cur_way yellow, others red, for YELLOW_TICKS ticks, then ALL_RED with cur_way incremented, wrapping NUM_WAYS-1 -> 0.
REQ-019 ped_req high SHALL set ped pending; pending clears on the cycle WALK is entered; ped_req during WALK or on its entry cycle is dropped.
REQ-020 WALK SHALL hold all ways red, walk_out=1, for WALK_TICKS ticks, then ALL_RED with cur_way unchanged.
REQ-021 flash_en high SHALL force FLASH on the next edge from any state, clearing phase counter and tick prescaler.
REQ-022 In FLASH, way 0 SHALL alternate yellow/off and other ways red/off, toggling on each tick, starting lit; walk_out=0.
REQ-023 flash_en low while in FLASH SHALL go to ALL_RED with cur_way=0, pending retained.
REQ-024 Outputs SHALL be registered; light_out, color_out, walk_out change one cycle after the state transition's causing tick.
REQ-025 Counter widths SHALL be $clog2(max value+1); no overflow for legal parameters.

Reset
REQ-026 RST SHALL dominate flash_en and ped_req.
REQ-027 On RST: state ALL_RED, cur_way 0, all ways red, color_out 100, walk_out 0, tick_out 0, pending 0, counters 0.
REQ-028 RST mid-phase SHALL abandon the phase with no partial-phase completion.

Configuration
REQ-029 Macro TRAFFIC_PED_WALK_EN SHALL compile in ped_req latch, WALK state and walk_out driving.
REQ-030 Without TRAFFIC_PED_WALK_EN, ped_req SHALL be ignored, walk_out tied 0, ALL_RED always exits to GREEN.

Structure
REQ-031 Shared package traffic_pkg SHALL hold lamp-code constants and the state enum typedef.
REQ-032 Tick prescaler SHALL be sub-module traffic_tick_gen (params TICK_DIV; ports CLK_50MHz, RST, clr, tick).

Verification (NUM_WAYS=3, TICK_DIV=4, GREEN=3, YELLOW=2, ALLRED=1, WALK=2)
REQ-033 RST then idle -> ticks every 4 cycles; sequence ALL_RED 1, way0 GREEN 3, YELLOW 2, ALL_RED 1, way1 green; after way2 yellow cur_way wraps to 0.
REQ-034 ped_req one-cycle pulse during way0 GREEN -> after following ALL_RED, WALK 2 ticks, walk_out=1, all light_out=010101, then ALL_RED, way1 GREEN.
REQ-035 ped_req held high throughout WALK -> no second WALK unless reasserted after WALK entry cycle.
REQ-036 flash_en asserted mid-GREEN -> next cycle FLASH; way0 yellow/off, ways1-2 red/off toggling each tick; deassert -> ALL_RED, cur_way 0.
REQ-037 RST asserted mid-YELLOW of way2 with flash_en=1 -> next cycle REQ-027 values, no FLASH.
REQ-038 Build without TRAFFIC_PED_WALK_EN, pulse ped_req -> walk_out stays 0, sequence identical to REQ-033.
